// File: rtl/riscv_alu_issue.sv
// riscv_alu_issue: ID->EX issue register for the 64-bit core.
// Decodes opcode/funct3/funct7[5] into an ALU control code, selects the ALU
// operands, and holds them in a single valid/ready stage. Branches are
// resolved combinationally from the registered funct3 and the ALU flags.

`ifndef ALU_ADD
`define ALU_ADD 4'b0000
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'b0001
`endif
`ifndef ALU_AND
`define ALU_AND 4'b0010
`endif
`ifndef ALU_OR
`define ALU_OR  4'b0011
`endif
`ifndef ALU_SLL
`define ALU_SLL 4'b0100
`endif
`ifndef ALU_SRL
`define ALU_SRL 4'b0101
`endif

module riscv_alu_issue #(
  // Only 64 is supported: shift amounts are taken as 6 bits.
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            id_valid_i,
  output logic            id_ready_o,
  input  logic [6:0]      id_opcode_i,
  input  logic [2:0]      id_funct3_i,
  input  logic            id_funct7b5_i,
  input  logic [XLEN-1:0] id_rs1_i,
  input  logic [XLEN-1:0] id_rs2_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic            flush_i,
  output logic [3:0]      alu_control_o,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            alu_zero_i,
  input  logic            alu_lt_i,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [XLEN-1:0] ex_result_o,
  output logic            ex_is_branch_o,
  output logic            branch_taken_o,
  output logic [XLEN-1:0] branch_target_o,
  output logic            illegal_o
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;

  // Everything the EX stage needs about one instruction.
  typedef struct packed {
    logic [3:0]      ctrl;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] target;
    logic [2:0]      funct3;
    logic            is_branch;
    logic            illegal;
  } ex_req_t;

  ex_req_t dec;
  ex_req_t ex_q;
  logic    ex_valid_q;
  logic    capture;
  logic    xfer;

  // Ready is independent of id_valid_i so decode can use it to steer.
  assign id_ready_o = !ex_valid_q || ex_ready_i;
  assign capture    = id_valid_i && id_ready_o && !flush_i;
  assign xfer       = ex_valid_q && ex_ready_i;

  // Decode the offered instruction into the next EX register contents.
  always_comb begin
    dec         = '0;
    dec.ctrl    = `ALU_ADD;
    dec.funct3  = id_funct3_i;
    dec.target  = id_pc_i + id_imm_i;
    dec.illegal = 1'b0;
    unique case (id_opcode_i)
      OP_R: begin
        dec.a = id_rs1_i;
        dec.b = id_rs2_i;
        case (id_funct3_i)
          3'b000: dec.ctrl = id_funct7b5_i ? `ALU_SUB : `ALU_ADD;
          3'b001: dec.ctrl = `ALU_SLL;
          // funct7b5=1 (arithmetic right shift) decodes as illegal.
          3'b101: begin
            dec.ctrl    = `ALU_SRL;
            dec.illegal = id_funct7b5_i;
          end
          3'b111: dec.ctrl = `ALU_AND;
          3'b110: dec.ctrl = `ALU_OR;
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_I: begin
        dec.a = id_rs1_i;
        dec.b = id_imm_i;
        case (id_funct3_i)
          3'b000: dec.ctrl = `ALU_ADD;
          3'b111: dec.ctrl = `ALU_AND;
          3'b110: dec.ctrl = `ALU_OR;
          // Immediate shifts carry a 6-bit shamt; upper imm bits must be clear.
          3'b001: begin
            dec.ctrl    = `ALU_SLL;
            dec.illegal = |id_imm_i[11:6];
          end
          3'b101: begin
            dec.ctrl    = `ALU_SRL;
            dec.illegal = |id_imm_i[11:6];
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_LD, OP_ST: begin
        dec.a = id_rs1_i;
        dec.b = id_imm_i;
      end
      OP_BR: begin
        dec.a         = id_rs1_i;
        dec.b         = id_rs2_i;
        dec.ctrl      = `ALU_SUB;
        dec.is_branch = 1'b1;
        case (id_funct3_i)
          F3_BEQ, F3_BNE, F3_BLT: dec.illegal = 1'b0;
          default:                dec.illegal = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal instructions still flow through, but drive a benign ALU op.
    if (dec.illegal) begin
      dec.ctrl      = `ALU_ADD;
      dec.a         = '0;
      dec.b         = '0;
      dec.is_branch = 1'b0;
    end
  end

  // EX register: flush beats capture; a stall simply holds the contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
      ex_q.ctrl  <= `ALU_ADD;
    end else if (flush_i) begin
      ex_valid_q <= 1'b0;
    end else if (capture) begin
      ex_valid_q <= 1'b1;
      ex_q       <= dec;
    end else if (xfer) begin
      ex_valid_q <= 1'b0;
    end
  end

  // Branch resolution from the registered funct3 and the live ALU flags.
  // BLT uses the sign of rs1-rs2 without overflow correction.
  always_comb begin
    branch_taken_o = 1'b0;
    if (ex_valid_q && ex_q.is_branch) begin
      case (ex_q.funct3)
        F3_BEQ:  branch_taken_o = alu_zero_i;
        F3_BNE:  branch_taken_o = !alu_zero_i;
        F3_BLT:  branch_taken_o = alu_lt_i;
        default: branch_taken_o = 1'b0;
      endcase
    end
  end

  assign alu_control_o   = ex_q.ctrl;
  assign alu_a_o         = ex_q.a;
  assign alu_b_o         = ex_q.b;
  assign ex_valid_o      = ex_valid_q;
  assign ex_result_o     = alu_result_i;
  assign ex_is_branch_o  = ex_q.is_branch;
  assign branch_target_o = ex_q.target;
  assign illegal_o       = ex_valid_q && ex_q.illegal;

endmodule

// File: doc/riscv_alu_issue.md
Name: riscv_alu_issue

Overview:
- EX-stage issue register that sits between instruction decode and riscv_alu.
- Decodes RISC-V opcode, funct3 and funct7[5] into the 4-bit ALU control code, selects the ALU operands and holds them in a valid/ready pipeline register.
- Consumes the ALU result, zero and less-than flags to resolve branches and compute the branch target.
- Forms the ID->EX boundary of the 64-bit core.

Parameters:
- XLEN, 64, datapath width. Only 64 is supported, because shift amounts are 6 bits.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- id_valid_i  in  1  decode offers an instruction.
- id_ready_o  out  1  block accepts the instruction this cycle.
- id_opcode_i  in  7  instr[6:0].
- id_funct3_i  in  3  instr[14:12].
- id_funct7b5_i  in  1  instr[30].
- id_rs1_i  in  XLEN  rs1 value.
- id_rs2_i  in  XLEN  rs2 value.
- id_imm_i  in  XLEN  sign-extended immediate.
- id_pc_i  in  XLEN  instruction PC.
- flush_i  in  1  kill the held instruction and any instruction offered this cycle.
- alu_control_o  out  4  to riscv_alu alu_control_i.
- alu_a_o  out  XLEN  to alu_a_i.
- alu_b_o  out  XLEN  to alu_b_i.
- alu_result_i  in  XLEN  from alu_result_o.
- alu_zero_i  in  1  from zero_o.
- alu_lt_i  in  1  from lt_o.
- ex_valid_o  out  1  EX holds a valid instruction.
- ex_ready_i  in  1  downstream accepts the EX instruction.
- ex_result_o  out  XLEN  alu_result_i passthrough.
- ex_is_branch_o  out  1  held instruction is a conditional branch.
- branch_taken_o  out  1  branch condition true; qualified by ex_valid_o.
- branch_target_o  out  XLEN  pc + imm, registered.
- illegal_o  out  1  held instruction is unsupported; qualified by ex_valid_o.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - ex_valid_o=0; alu_control_o=`ALU_ADD; alu_a_o=0; alu_b_o=0.
  - branch_target_o=0; ex_is_branch_o=0; illegal_o=0.
  - Reset asserted mid-operation discards the held instruction immediately, with no downstream transfer.
- Handshake:
  - id_ready_o = !ex_valid_o || ex_ready_i. This is combinational and does not depend on id_valid_i.
  - Capture occurs when id_valid_i && id_ready_o && !flush_i.
  - Transfer out occurs when ex_valid_o && ex_ready_i.
  - Simultaneous transfer out and capture: the register reloads in the same edge and ex_valid_o stays 1.
  - Transfer out without capture: ex_valid_o clears on that edge.
- Stall: while ex_valid_o && !ex_ready_i, all registered outputs hold steady and id_ready_o=0.
- Flush: flush_i high at an edge clears ex_valid_o and blocks capture, regardless of the handshake. Flush has priority over capture.
- Latency: one cycle from capture to ex_valid_o. ALU outputs are combinational from the registers, so ex_result_o, branch_taken_o and illegal_o are valid in the same cycle as ex_valid_o.
- Decode (registered at capture):
  - R-type 0110011:
    - a=rs1, b=rs2.
    - funct3 000: ADD, or SUB if funct7b5=1.
    - funct3 001: SLL.
    - funct3 101: SRL if funct7b5=0, else illegal.
    - funct3 111: AND.
    - funct3 110: OR.
    - Other funct3: illegal.
  - I-ALU 0010011:
    - a=rs1, b=imm.
    - funct3 000: ADD. funct7b5 is ignored.
    - funct3 111: AND. funct3 110: OR.
    - funct3 001: SLL. Requires imm[11:6]=0, else illegal.
    - funct3 101: SRL. Requires imm[11:6]=0, else illegal.
    - Other funct3: illegal.
  - Load 0000011 and store 0100011: ADD, a=rs1, b=imm. Produces the effective address.
  - Branch 1100011:
    - SUB, a=rs1, b=rs2; ex_is_branch_o=1.
    - Accepted funct3: 000 BEQ, 001 BNE, 100 BLT. Any other funct3 is illegal.
  - Any other opcode: illegal.
- Illegal instructions: alu_control_o=`ALU_ADD, alu_a_o=0, alu_b_o=0, ex_is_branch_o=0. They still occupy the stage and transfer out normally.
- Branch condition (combinational from the registered funct3 and the ALU flags):
  - BEQ: taken = alu_zero_i.
  - BNE: taken = !alu_zero_i.
  - BLT: taken = alu_lt_i (sign of rs1-rs2). Signed overflow is not corrected; this is a documented limitation.
  - branch_taken_o=0 when not a branch or when ex_valid_o=0.
- Branch target: branch_target_o = id_pc_i + id_imm_i, computed at capture modulo 2^64 (wraps).
- Control codes: all control codes use the `ALU_* macros from riscv_defs.v.

Test Plan:
- Reset: hold rst_ni=0 with id_valid_i=1 -> ex_valid_o=0, alu_control_o=`ALU_ADD, id_ready_o=1. Release rst_ni and capture R-type SUB with rs1=10, rs2=3 -> next cycle ex_valid_o=1, alu_control_o=`ALU_SUB, ex_result_o=7.
- Branches:
  - BEQ with rs1=rs2=5, pc=0x1000, imm=0x20 -> branch_taken_o=1, branch_target_o=0x1020.
  - BNE with the same operands -> branch_taken_o=0.
  - BLT with rs1=-1, rs2=1 -> branch_taken_o=1.
- Immediate shifts:
  - SLLI with imm=63, rs1=1 -> ex_result_o=0x8000_0000_0000_0000.
  - SRLI with imm=0x43 -> illegal_o=1, ex_is_branch_o=0.
- Backpressure: ex_ready_i=0 for 3 cycles with id_valid_i=1 -> id_ready_o=0 and outputs stable. Raise ex_ready_i -> back-to-back transfer, ex_valid_o stays 1, second instruction appears on the next edge.
- Flush: flush_i=1 together with a valid capture while EX holds an ADD -> next cycle ex_valid_o=0 and no capture.
- Wrap and illegal:
  - pc=0xFFFF_FFFF_FFFF_FFF0 with imm=0x20 -> branch_target_o=0x10.
  - opcode 0110111 (LUI) -> illegal_o=1.
  - R-type funct3=101, funct7b5=1 (SRA) -> illegal_o=1.
